// File: rtl/devbus_ctl.sv
// Two-requester controller for the devboard multiplexed address/data bus.
// Runs one ADDR/HOLD/ACCESS/TURN cycle at a time and returns a one-cycle response to the owner.
module devbus_ctl #(
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  rq_valid,
    output logic [1:0]  rq_ready,
    input  logic [1:0]  rq_we,
    input  logic [1:0]  rq_io,
    input  logic [19:0] rq_addr0,
    input  logic [19:0] rq_addr1,
    input  logic [15:0] rq_wdata0,
    input  logic [15:0] rq_wdata1,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [3:0]  bus_hi,
    output logic [15:0] bus_lo_o,
    input  logic [15:0] bus_lo_i,
    output logic        bus_lo_oe,
    output logic        ale,
    output logic        oe_n,
    output logic        we_n,
    output logic        pio
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        HOLD,
        ACCESS,
        TURN
    } state_t;

    state_t      state, state_nx;
    logic        owner;
    logic        last_grant;
    logic        we_r;
    logic        io_r;
    logic [19:0] addr_r;
    logic [15:0] wdata_r;
    logic [15:0] rdata_r;
    logic [3:0]  cnt;
    logic        win;
    logic [1:0]  grant;
    logic        accept;

    // On contention the requester that was not served last wins; grant is gated by rstn
    // so nothing is offered while reset is held.
    always_comb begin
        win    = (rq_valid == 2'b11) ? ~last_grant : rq_valid[1];
        grant  = '0;
        if (state == IDLE && rstn)
            grant = rq_valid & (win ? 2'b10 : 2'b01);
        accept   = |grant;
        rq_ready = grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ADDR;
            ADDR:    state_nx = HOLD;
            HOLD:    state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = TURN;
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            we_r       <= 1'b0;
            io_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                owner      <= win;
                last_grant <= win;
                we_r       <= rq_we[win];
                io_r       <= rq_io[win];
                addr_r     <= win ? rq_addr1 : rq_addr0;
                wdata_r    <= win ? rq_wdata1 : rq_wdata0;
            end
            if (state == HOLD)
                cnt <= 4'(WAIT - 1);
            else if (state == ACCESS && cnt != '0)
                cnt <= cnt - 4'd1;
            if (state == ACCESS && cnt == '0 && !we_r)
                rdata_r <= bus_lo_i;
        end
    end

    // Strobes decode straight from the state register so they only move at state boundaries.
    always_comb begin
        ale       = 1'b0;
        oe_n      = 1'b1;
        we_n      = 1'b1;
        pio       = 1'b0;
        bus_lo_oe = 1'b0;
        bus_lo_o  = '0;
        rsp_valid = '0;
        bus_hi    = addr_r[19:16];
        rsp_rdata = rdata_r;
        case (state)
            ADDR: begin
                ale       = 1'b1;
                pio       = io_r;
                bus_lo_oe = 1'b1;
                bus_lo_o  = addr_r[15:0];
            end
            HOLD: begin
                pio       = io_r;
                bus_lo_oe = we_r;
                bus_lo_o  = we_r ? wdata_r : addr_r[15:0];
            end
            ACCESS: begin
                pio       = io_r;
                oe_n      = 1'b0;
                we_n      = ~we_r;
                bus_lo_oe = we_r;
                bus_lo_o  = wdata_r;
            end
            TURN: begin
                pio       = io_r;
                bus_lo_oe = we_r;
                bus_lo_o  = wdata_r;
                rsp_valid = owner ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_devbus_ctl.sv
// Directed bench for devbus_ctl: per-cycle bus checks plus a response scoreboard,
// with two extra instances exercising the WAIT=1 and WAIT=15 extremes.
module tb_devbus_ctl;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  rq_valid, rq_we, rq_io, rq_ready, rsp_valid;
    logic [19:0] rq_addr0, rq_addr1;
    logic [15:0] rq_wdata0, rq_wdata1, rsp_rdata, bus_lo_o, bus_lo_i;
    logic [15:0] rd_model = 16'h0000;
    logic [3:0]  bus_hi;
    logic        bus_lo_oe, ale, oe_n, we_n, pio;

    logic        s_valid = 1'b0;
    logic [1:0]  r1_ready, r1_rsp, r15_ready, r15_rsp;
    logic [15:0] r1_rdata, r1_lo, r15_rdata, r15_lo;
    logic [3:0]  r1_hi, r15_hi;
    logic        r1_oe, r1_ale, r1_oen, r1_wen, r1_pio;
    logic        r15_oe, r15_ale, r15_oen, r15_wen, r15_pio;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  mask;
        logic        we;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t e_in, e_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM/pio model: drives the expected read word only while the transceiver is reading.
    assign bus_lo_i = (!oe_n && we_n) ? rd_model : 16'hDEAD;

    devbus_ctl #(.WAIT(W)) dut (
        .clk(clk), .rstn(rstn), .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we),
        .rq_io(rq_io), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1), .rq_wdata0(rq_wdata0),
        .rq_wdata1(rq_wdata1), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bus_hi(bus_hi),
        .bus_lo_o(bus_lo_o), .bus_lo_i(bus_lo_i), .bus_lo_oe(bus_lo_oe), .ale(ale),
        .oe_n(oe_n), .we_n(we_n), .pio(pio)
    );

    devbus_ctl #(.WAIT(1)) dut1 (
        .clk(clk), .rstn(rstn), .rq_valid({1'b0, s_valid}), .rq_ready(r1_ready), .rq_we(2'b00),
        .rq_io(2'b00), .rq_addr0(20'h0), .rq_addr1(20'h0), .rq_wdata0(16'h0),
        .rq_wdata1(16'h0), .rsp_valid(r1_rsp), .rsp_rdata(r1_rdata), .bus_hi(r1_hi),
        .bus_lo_o(r1_lo), .bus_lo_i(16'h1357), .bus_lo_oe(r1_oe), .ale(r1_ale),
        .oe_n(r1_oen), .we_n(r1_wen), .pio(r1_pio)
    );

    devbus_ctl #(.WAIT(15)) dut15 (
        .clk(clk), .rstn(rstn), .rq_valid({1'b0, s_valid}), .rq_ready(r15_ready), .rq_we(2'b00),
        .rq_io(2'b00), .rq_addr0(20'h0), .rq_addr1(20'h0), .rq_wdata0(16'h0),
        .rq_wdata1(16'h0), .rsp_valid(r15_rsp), .rsp_rdata(r15_rdata), .bus_hi(r15_hi),
        .bus_lo_o(r15_lo), .bus_lo_i(16'h1357), .bus_lo_oe(r15_oe), .ale(r15_ale),
        .oe_n(r15_oen), .we_n(r15_wen), .pio(r15_pio)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push: every granted request expects one response WAIT+3 cycles after acceptance.
    always @(negedge clk) begin
        if (rstn && (rq_valid & rq_ready) != 2'b00) begin
            e_in.mask = rq_ready;
            e_in.we   = rq_ready[1] ? rq_we[1] : rq_we[0];
            e_in.data = rd_model;
            e_in.due  = cyc + 3 + W;
            sbq.push_back(e_in);
        end
    end

    always @(negedge clk) begin
        chk("ale_during_oe", {31'b0, ale & ~oe_n}, 32'd0);
        if (rsp_valid != 2'b00) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", {30'b0, rsp_valid}, 32'd0);
            end else begin
                e_out = sbq.pop_front();
                chk("rsp_owner", {30'b0, rsp_valid}, {30'b0, e_out.mask});
                chk("rsp_cycle", cyc, e_out.due);
                if (!e_out.we) chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, e_out.data});
            end
        end
    end

    task automatic drive(input int idx, input logic we, input logic io,
                         input logic [19:0] a, input logic [15:0] wd);
        if (idx == 0) begin
            rq_we[0] = we; rq_io[0] = io; rq_addr0 = a; rq_wdata0 = wd; rq_valid[0] = 1'b1;
        end else begin
            rq_we[1] = we; rq_io[1] = io; rq_addr1 = a; rq_wdata1 = wd; rq_valid[1] = 1'b1;
        end
    endtask

    // Returns with the DUT in ADDR, #1 after the acceptance edge; a_cyc is the ADDR cycle.
    task automatic wait_acc(input int idx, output int a_cyc);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rq_ready[idx]) got = 1'b1;
        end
        chk("grant_seen", {31'b0, got}, 32'd1);
        if (got) chk("grant_mask", {30'b0, rq_ready}, (idx == 0) ? 32'd1 : 32'd2);
        @(posedge clk); #1;
        rq_valid[idx] = 1'b0;
        a_cyc = cyc;
    endtask

    task automatic walk(input logic we, input logic io, input logic [19:0] a,
                        input logic [15:0] wd, input int owner, input bit to_idle);
        @(negedge clk);
        chk("addr_ale", {31'b0, ale}, 32'd1);
        chk("addr_lo", {16'b0, bus_lo_o}, {16'b0, a[15:0]});
        chk("addr_oe", {31'b0, bus_lo_oe}, 32'd1);
        chk("addr_hi", {28'b0, bus_hi}, {28'b0, a[19:16]});
        chk("addr_pio", {31'b0, pio}, {31'b0, io});
        chk("addr_oen", {31'b0, oe_n}, 32'd1);
        @(negedge clk);
        chk("hold_ale", {31'b0, ale}, 32'd0);
        chk("hold_oe", {31'b0, bus_lo_oe}, {31'b0, we});
        chk("hold_oen", {31'b0, oe_n}, 32'd1);
        chk("hold_hi", {28'b0, bus_hi}, {28'b0, a[19:16]});
        chk("hold_pio", {31'b0, pio}, {31'b0, io});
        if (we) chk("hold_wdata", {16'b0, bus_lo_o}, {16'b0, wd});
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk("acc_oen", {31'b0, oe_n}, 32'd0);
            chk("acc_wen", {31'b0, we_n}, {31'b0, ~we});
            chk("acc_oe", {31'b0, bus_lo_oe}, {31'b0, we});
            chk("acc_hi", {28'b0, bus_hi}, {28'b0, a[19:16]});
            chk("acc_pio", {31'b0, pio}, {31'b0, io});
            if (we) chk("acc_wdata", {16'b0, bus_lo_o}, {16'b0, wd});
        end
        @(negedge clk);
        chk("turn_oen", {31'b0, oe_n}, 32'd1);
        chk("turn_wen", {31'b0, we_n}, 32'd1);
        chk("turn_oe", {31'b0, bus_lo_oe}, {31'b0, we});
        chk("turn_rsp", {30'b0, rsp_valid}, (owner == 0) ? 32'd1 : 32'd2);
        chk("turn_pio", {31'b0, pio}, {31'b0, io});
        if (to_idle) begin
            @(negedge clk);
            chk("idle_pio", {31'b0, pio}, 32'd0);
            chk("idle_hi", {28'b0, bus_hi}, {28'b0, a[19:16]});
            chk("idle_rsp", {30'b0, rsp_valid}, 32'd0);
            chk("idle_oe", {31'b0, bus_lo_oe}, 32'd0);
            if (!we) chk("idle_rdata_hold", {16'b0, rsp_rdata}, {16'b0, rd_model});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n, lat1, lat15, acc1, acc15;
        int gc[4];
        logic [1:0] gm[4];
        bit g;

        rq_valid = 2'b11; rq_we = 2'b00; rq_io = 2'b00;
        rq_addr0 = 20'h0; rq_addr1 = 20'h0; rq_wdata0 = 16'h0; rq_wdata1 = 16'h0;
        #2;
        chk("rst_ale", {31'b0, ale}, 32'd0);
        chk("rst_oen", {31'b0, oe_n}, 32'd1);
        chk("rst_wen", {31'b0, we_n}, 32'd1);
        chk("rst_pio", {31'b0, pio}, 32'd0);
        chk("rst_oe", {31'b0, bus_lo_oe}, 32'd0);
        chk("rst_lo", {16'b0, bus_lo_o}, 32'd0);
        chk("rst_hi", {28'b0, bus_hi}, 32'd0);
        chk("rst_ready", {30'b0, rq_ready}, 32'd0);
        chk("rst_rsp", {30'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'b0, rsp_rdata}, 32'd0);

        // Release with both requesting: requester 0 must be offered the grant, then both withdraw.
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("release_grant", {30'b0, rq_ready}, 32'd1);
        rq_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("withdraw_ale", {31'b0, ale}, 32'd0);
        chk("withdraw_sb", sbq.size(), 32'd0);
        @(posedge clk); #1;

        // Single read from requester 0.
        rd_model = 16'hBEEF;
        drive(0, 1'b0, 1'b0, 20'h3_1234, 16'h0000);
        wait_acc(0, a1);
        walk(1'b0, 1'b0, 20'h3_1234, 16'h0000, 0, 1'b1);

        // Single I/O-space write from requester 1.
        drive(1, 1'b1, 1'b1, 20'h0_0010, 16'hA55A);
        wait_acc(1, a1);
        walk(1'b1, 1'b1, 20'h0_0010, 16'hA55A, 1, 1'b1);

        // Read by 0 immediately followed by a pending write from 1.
        rd_model = 16'h2468;
        drive(0, 1'b0, 1'b0, 20'h5_0F0F, 16'h0000);
        wait_acc(0, a1);
        drive(1, 1'b1, 1'b0, 20'h0_0ABC, 16'h1111);
        walk(1'b0, 1'b0, 20'h5_0F0F, 16'h0000, 0, 1'b0);
        wait_acc(1, a2);
        chk("b2b_spacing", a2 - a1, W + 4);
        walk(1'b1, 1'b0, 20'h0_0ABC, 16'h1111, 1, 1'b1);

        // Continuous contention: grants alternate, starting with 0 since 1 was served last.
        rd_model = 16'h7777;
        drive(0, 1'b0, 1'b0, 20'h1_0001, 16'h0000);
        drive(1, 1'b0, 1'b0, 20'h2_0002, 16'h0000);
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            if (rq_ready != 2'b00) begin
                gm[n] = rq_ready;
                gc[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        rq_valid = 2'b00;
        chk("cont_count", n, 32'd4);
        for (int i = 0; i < n; i++) begin
            chk("cont_order", {30'b0, gm[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) chk("cont_spacing", gc[i] - gc[i-1], W + 4);
        end
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        chk("cont_drained", sbq.size(), 32'd0);
        @(posedge clk); #1;

        // Reset asserted in the middle of a write's ACCESS phase.
        drive(0, 1'b1, 1'b0, 20'hF_FFFF, 16'h5A5A);
        wait_acc(0, a1);
        repeat (3) @(negedge clk);
        chk("prerst_oen", {31'b0, oe_n}, 32'd0);
        chk("prerst_wen", {31'b0, we_n}, 32'd0);
        #1 rstn = 1'b0;
        #1;
        chk("async_oen", {31'b0, oe_n}, 32'd1);
        chk("async_wen", {31'b0, we_n}, 32'd1);
        chk("async_oe", {31'b0, bus_lo_oe}, 32'd0);
        chk("async_hi", {28'b0, bus_hi}, 32'd0);
        chk("async_lo", {16'b0, bus_lo_o}, 32'd0);
        sbq.delete();
        repeat (3) begin
            @(negedge clk);
            chk("inrst_rsp", {30'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1 rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("postrst_rsp", {30'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rd_model = 16'hC3C3;
        drive(1, 1'b0, 1'b1, 20'h8_1357, 16'h0000);
        wait_acc(1, a1);
        walk(1'b0, 1'b1, 20'h8_1357, 16'h0000, 1, 1'b1);

        // WAIT extremes on the side instances, started together.
        s_valid = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge clk);
            if (r1_ready[0] && r15_ready[0]) g = 1'b1;
        end
        chk("ext_grant", {31'b0, g}, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        a1 = cyc;
        lat1 = -1; lat15 = -1; acc1 = 0; acc15 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!r1_oen) acc1++;
            if (!r15_oen) acc15++;
            if (r1_rsp[0] && lat1 < 0) begin
                lat1 = cyc - a1 + 1;
                chk("w1_rdata", {16'b0, r1_rdata}, 32'h1357);
            end
            if (r15_rsp[0] && lat15 < 0) begin
                lat15 = cyc - a1 + 1;
                chk("w15_rdata", {16'b0, r15_rdata}, 32'h1357);
            end
        end
        chk("w1_latency", lat1, 32'd4);
        chk("w15_latency", lat15, 32'd18);
        chk("w1_access_len", acc1, 32'd1);
        chk("w15_access_len", acc15, 32'd15);

        chk("final_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
